idli_sqi_m: RTL and testbench

SQI memory controller for an external quad-SPI serial SRAM in sequential quad mode. Each nibble-serial address arrives low nibble first, in step with the PC slice stream, and is captured into a holding register. The block then issues a READ (0x03) or WRITE (0x02) transaction on the quad bus and streams data nibbles until told to stop. It sits directly downstream of the PC: the PC slice is its address source for instruction fetch.

---
 rtl/idli_pkg.sv | 7 +
 rtl/idli_sqi_addr_m.sv | 17 +
 rtl/idli_sqi_m.sv | 108 ++++++++++
 tb/tb_idli_sqi_m.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the idli core.
package idli_pkg;
  typedef logic [3:0] sqi_data_t;
  typedef enum logic [2:0] {IDLE, CAPT, CMD, ADDR, DUMMY, RDATA, WDATA} sqi_state_t;
  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
endpackage

// File: rtl/idli_sqi_addr_m.sv
// idli_sqi_addr_m: 16-bit address register, shifts in low nibble first, out high nibble first.
module idli_sqi_addr_m import idli_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      capture,
  input  logic      shift,
  input  sqi_data_t nib_i,
  output sqi_data_t nib_o
);
  logic [15:0] addr_q, addr_d;
  always_comb addr_d = capture ? {nib_i, addr_q[15:4]} : shift ? {addr_q[11:0], 4'h0} : addr_q;
  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else addr_q <= addr_d;
  end
  assign nib_o = addr_q[15:12];
endmodule

// File: rtl/idli_sqi_m.sv
// idli_sqi_m: SQI controller for a quad-SPI serial SRAM in sequential mode.
// Outputs are registered from the next-state view, so each output reflects the state it is shown in.
module idli_sqi_m import idli_pkg::*; #(
  parameter int DUMMY_CYCLES = 2
) (
  input  logic      i_sqi_gck,
  input  logic      i_sqi_rst,
  input  logic      i_sqi_req,
  input  logic      i_sqi_wr,
  input  sqi_data_t i_sqi_addr,
  input  logic      i_sqi_stop,
  input  sqi_data_t i_sqi_wr_data,
  output logic      o_sqi_wr_rdy,
  output sqi_data_t o_sqi_rd_data,
  output logic      o_sqi_rd_vld,
  output logic      o_sqi_busy,
  output logic      o_sqi_cs_n,
  output logic      o_sqi_sck_en,
  output sqi_data_t o_sqi_sio_o,
  output logic      o_sqi_sio_oe,
  input  sqi_data_t i_sqi_sio_i
);
  sqi_state_t state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic       wr_q, wr_d, last_q, last_d, fin, on_bus;
  logic       wr_rdy_q, wr_rdy_d, rd_vld_q, rd_vld_d, busy_q, busy_d;
  logic       cs_n_q, cs_n_d, sck_en_q, sck_en_d, oe_q, oe_d;
  sqi_data_t  rd_data_q, rd_data_d, sio_o_q, sio_o_d, addr_nib;
  logic [7:0] cmd;

  idli_sqi_addr_m u_addr (
    .clk     (i_sqi_gck),
    .rst     (i_sqi_rst),
    .capture ((state_q == IDLE && i_sqi_req) || state_q == CAPT),
    .shift   (state_d == ADDR),
    .nib_i   (i_sqi_addr),
    .nib_o   (addr_nib)
  );

  always_comb begin
    state_d = state_q;
    fin = wr_rdy_q && i_sqi_stop;
    case (state_q)
      IDLE:    if (i_sqi_req) state_d = CAPT;
      CAPT:    if (phase_q == 4'd2) state_d = CMD;
      CMD:     if (phase_q == 4'd1) state_d = ADDR;
      ADDR:    if (phase_q == 4'd3) state_d = wr_q ? WDATA : (DUMMY_CYCLES == 0 ? RDATA : DUMMY);
      DUMMY:   if (phase_q == 4'(DUMMY_CYCLES - 1)) state_d = RDATA;
      RDATA:   if (i_sqi_stop) state_d = IDLE;
      WDATA:   if (last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    phase_d = state_d == state_q ? phase_q + 4'd1 : 4'd0;
    wr_d = (state_q == IDLE && i_sqi_req) ? i_sqi_wr : wr_q;
    cmd = wr_q ? SQI_CMD_WRITE : SQI_CMD_READ;
    on_bus = state_d inside {CMD, ADDR, DUMMY, RDATA, WDATA};
    cs_n_d = !on_bus;
    sck_en_d = on_bus;
    oe_d = state_d inside {CMD, ADDR, WDATA};
    busy_d = state_d != IDLE;
    last_d = fin;
    wr_rdy_d = !fin && ((state_d == ADDR && phase_d == 4'd3 && wr_q) || state_d == WDATA);
    sio_o_d = state_d == CMD ? (phase_d == 4'd0 ? cmd[7:4] : cmd[3:0]) :
              state_d == ADDR ? addr_nib :
              state_d == WDATA ? (wr_rdy_q ? i_sqi_wr_data : sio_o_q) : 4'h0;
    rd_vld_d = state_q == RDATA;
    rd_data_d = state_q == RDATA ? i_sqi_sio_i : rd_data_q;
  end

  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      wr_q      <= 1'b0;
      last_q    <= 1'b0;
      wr_rdy_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_en_q  <= 1'b0;
      oe_q      <= 1'b0;
      sio_o_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      wr_q      <= wr_d;
      last_q    <= last_d;
      wr_rdy_q  <= wr_rdy_d;
      rd_vld_q  <= rd_vld_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      sck_en_q  <= sck_en_d;
      oe_q      <= oe_d;
      sio_o_q   <= sio_o_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign o_sqi_wr_rdy  = wr_rdy_q;
  assign o_sqi_rd_data = rd_data_q;
  assign o_sqi_rd_vld  = rd_vld_q;
  assign o_sqi_busy    = busy_q;
  assign o_sqi_cs_n    = cs_n_q;
  assign o_sqi_sck_en  = sck_en_q;
  assign o_sqi_sio_o   = sio_o_q;
  assign o_sqi_sio_oe  = oe_q;
endmodule

// File: tb/tb_idli_sqi_m.sv
// tb_idli_sqi_m: directed and random transactions checked cycle by cycle against the published timing.
module tb_idli_sqi_m;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, wr = 1'b0, stop = 1'b0;
  logic [3:0] addr = '0, wdata = '0, sio_i = '0;
  logic wr_rdy, rd_vld, busy, cs_n, sck_en, oe;
  logic [3:0] rd_data, sio_o;
  int checks = 0, errors = 0;
  logic pend_vld = 1'b0;
  logic [3:0] pend_data = '0;

  always #5 clk = ~clk;

  idli_sqi_m #(.DUMMY_CYCLES(2)) dut (
    .i_sqi_gck(clk), .i_sqi_rst(rst), .i_sqi_req(req), .i_sqi_wr(wr),
    .i_sqi_addr(addr), .i_sqi_stop(stop), .i_sqi_wr_data(wdata),
    .o_sqi_wr_rdy(wr_rdy), .o_sqi_rd_data(rd_data), .o_sqi_rd_vld(rd_vld),
    .o_sqi_busy(busy), .o_sqi_cs_n(cs_n), .o_sqi_sck_en(sck_en),
    .o_sqi_sio_o(sio_o), .o_sqi_sio_oe(oe), .i_sqi_sio_i(sio_i)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the req cycle; the task returns at the start of the first IDLE cycle after the transfer.
  task automatic txn(input bit w, input logic [15:0] a, input int n, input bit glitch, input int abort_at);
    logic [3:0] wq[$];
    logic [3:0] dq[$];
    int fin;
    logic e_busy, e_csn, e_oe, e_vld, e_rdy;
    logic [3:0] e_sio, e_rd;
    fin = w ? 10 + n : 12 + n;
    for (int c = 0; c < fin; c++) begin
      req = (c == 0) || (glitch && c == 7);
      wr = (c == 0) ? w : !w;
      addr = (c <= 3) ? a[4*c +: 4] : 4'($urandom);
      stop = (c == (w ? 8 + n : 11 + n)) || (glitch && c == 4);
      wdata = 4'($urandom);
      sio_i = 4'($urandom);
      rst = (c == abort_at);
      if (w && c >= 9) wq.push_back(wdata);
      if (!w && c >= 12) dq.push_back(sio_i);
      @(negedge clk);
      e_busy = c >= 1;
      e_csn = c < 4;
      e_oe = c >= 4 && (w || c <= 9);
      e_rdy = w && c >= 9 && c <= 8 + n;
      e_vld = (c == 0) ? pend_vld : (!w && c >= 13);
      e_sio = 4'h0;
      if (c == 5) e_sio = w ? 4'h2 : 4'h3;
      else if (c >= 6 && c <= 9) e_sio = a[4*(9-c) +: 4];
      else if (c >= 10 && w) e_sio = wq[c-10];
      e_rd = (c == 0) ? pend_data : (e_vld ? dq[c-13] : 4'h0);
      check("busy", 4'(busy), 4'(e_busy));
      check("cs_n", 4'(cs_n), 4'(e_csn));
      check("sck_en", 4'(sck_en), 4'(!e_csn));
      check("oe", 4'(oe), 4'(e_oe));
      if (e_oe) check("sio_o", sio_o, e_sio);
      check("wr_rdy", 4'(wr_rdy), 4'(e_rdy));
      check("rd_vld", 4'(rd_vld), 4'(e_vld));
      if (e_vld) check("rd_data", rd_data, e_rd);
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        rst = 1'b0;
        pend_vld = 1'b0;
        return;
      end
    end
    req = 1'b0;
    stop = 1'b0;
    pend_vld = !w;
    pend_data = w ? 4'h0 : dq[n-1];
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      req = 1'b0;
      stop = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 4'(busy), 4'h0);
      check("idle_cs_n", 4'(cs_n), 4'h1);
      check("idle_sck_en", 4'(sck_en), 4'h0);
      check("idle_oe", 4'(oe), 4'h0);
      check("idle_wr_rdy", 4'(wr_rdy), 4'h0);
      check("idle_rd_vld", 4'(rd_vld), 4'(pend_vld));
      if (pend_vld) check("idle_rd_data", rd_data, pend_data);
      pend_vld = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_n", 4'(cs_n), 4'h1);
    check("rst_sck_en", 4'(sck_en), 4'h0);
    check("rst_oe", 4'(oe), 4'h0);
    check("rst_sio_o", sio_o, 4'h0);
    check("rst_rd_vld", 4'(rd_vld), 4'h0);
    check("rst_wr_rdy", 4'(wr_rdy), 4'h0);
    check("rst_busy", 4'(busy), 4'h0);
    check("rst_rd_data", rd_data, 4'h0);
    @(posedge clk);
    #1;
    txn(1'b0, 16'h1234, 3, 1'b0, -1);
    idle(2);
    txn(1'b1, 16'hBEEF, 2, 1'b0, -1);
    idle(1);
    txn(1'b0, 16'($urandom), 2, 1'b0, -1);
    txn(1'b0, 16'($urandom), 4, 1'b0, -1);
    idle(1);
    txn(1'b0, 16'($urandom), 3, 1'b1, -1);
    txn(1'b1, 16'($urandom), 3, 1'b1, -1);
    idle(1);
    txn(1'b1, 16'($urandom), 1, 1'b0, -1);
    idle(1);
    txn(1'b0, 16'($urandom), 5, 1'b0, 11);
    idle(2);
    txn(1'b0, 16'hFFFF, 41, 1'b0, -1);
    idle(1);
    for (int i = 0; i < 12; i++) begin
      txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)), -1);
      idle($urandom_range(0, 2));
    end
    idle(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
